uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: consumes the serial line produced by `UartTransmitter`, or by the host PC, and delivers bytes to the FPGA fabric. It runs on the system clock and is paced by a 16× baud tick. It samples each bit at mid-bit, checks optional parity and the stop bit, and buffers good bytes in a 16-entry show-ahead FIFO. Its frame format and state encoding mirror the transmitter, so a loopback needs no glue logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 76 +++++++
 rtl/uart_receiver.sv | 198 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversampling ratio
// and the parity helper. Used by both the transmitter and the receiver so
// that loopback needs no glue logic.
package uart_pkg;

  // FSM state encoding, identical on the TX and RX side.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Baud ticks per bit time.
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Expected parity bit: odd selects odd parity, 0 selects even parity.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always presented on data_o
// (zero when empty). A push into a full FIFO is accepted only if a pop
// happens in the same cycle. DEPTH must be a power of two so the pointers
// wrap naturally.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; clear_i empties the FIFO synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, data_o masks empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises rx, samples each bit at mid-bit using
// the oversampling tick, checks optional parity and the stop bit, and
// buffers good bytes in a show-ahead FIFO. Bad frames are dropped with a
// one-cycle error pulse. FIFO_DEPTH must be a power of two; OVERSAMPLE must
// be even and at least 4.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          tick_16x,
  input  logic                          rx,
  input  logic                          parity_enable,
  input  logic                          parity_odd_even,
  input  logic                          rx_read,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [2:0]                    current_state
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

  logic              rx_meta_q, rx_s_q;
  uart_state_e       state_q, state_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              push;
  logic              fifo_empty, fifo_full;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else if (!enable) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state and datapath logic; everything advances only on a baud tick.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    if (tick_16x) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            scnt_d    = '0;
            par_en_d  = parity_enable;
            par_odd_d = parity_odd_even;
            par_bad_d = 1'b0;
            state_d   = ST_START;
          end
        end
        ST_START: begin
          if (scnt_q == SCNT_MID) begin
            if (!rx_s_q) begin
              scnt_d    = '0;
              bit_idx_d = '0;
              state_d   = ST_DATA;
            end else begin
              // Start bit did not hold to mid-bit: treat as line noise.
              state_d = ST_IDLE;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_DATA: begin
          if (scnt_q == SCNT_LAST) begin
            shreg_d   = {rx_s_q, shreg_q[7:1]};
            scnt_d    = '0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_PARITY: begin
          if (scnt_q == SCNT_LAST) begin
            par_bad_d = (rx_s_q != parity_bit(shreg_q, par_odd_q));
            scnt_d    = '0;
            state_d   = ST_STOP;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_STOP: begin
          if (scnt_q == SCNT_LAST) begin
            // Framing error outranks parity error; only clean frames are kept.
            if (!rx_s_q)        frame_err_d  = 1'b1;
            else if (par_bad_q) parity_err_d = 1'b1;
            else                push         = 1'b1;
            state_d = ST_IDLE;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A good byte is lost only if the FIFO is full and nobody pops this cycle.
  assign overrun_d = push && fifo_full && !rx_read;

  // FSM, datapath and error-flag registers; enable low acts as a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scnt_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (!enable) begin
      state_q      <= ST_IDLE;
      scnt_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (!enable),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (rx_read),
    .data_o  (rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign rx_valid      = !fifo_empty;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != ST_IDLE);
  assign current_state = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a table of single frames with their
// expected outcome, followed by hand-written sequences for glitch,
// overrun, push-with-pop at full, and mid-frame reset/disable.
module tb_uart_receiver;

  localparam int TICK_DIV = 4;              // clk cycles per tick
  localparam int BIT_CLK  = 16 * TICK_DIV;  // clk cycles per bit
  localparam int IDLE_CLK = 2 * BIT_CLK;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       tick_16x;
  logic       rx;
  logic       parity_enable;
  logic       parity_odd_even;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] current_state;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  uart_receiver #(.FIFO_DEPTH(16), .OVERSAMPLE(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .tick_16x        (tick_16x),
    .rx              (rx),
    .parity_enable   (parity_enable),
    .parity_odd_even (parity_odd_even),
    .rx_read         (rx_read),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .fifo_count      (fifo_count),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .busy            (busy),
    .current_state   (current_state)
  );

  // Clock and baud tick.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int tdiv;
    tdiv = 0;
    tick_16x = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % TICK_DIV;
      tick_16x = (tdiv == 0);
    end
  end

  // Count error-flag cycles so pulses can be checked as deltas.
  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
    if (overrun)    ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, LSB first, optional parity bit, then the stop bit value.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
    if (pen) begin
      rx = pbit;
      wait_clk(BIT_CLK);
    end
    rx = stop;
    wait_clk(BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  // Raise rx_read exactly in the cycle of the STOP sampling tick (16th tick in STOP).
  task automatic pop_at_push();
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < 16 && guard < 4000) begin
      @(negedge clk);
      #1;
      guard++;
      if (current_state == 3'd4 && tick_16x) n++;
    end
    check("pop_at_push_found", (n == 16), 1);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  // Abort a frame in DATA bit 3 by reset or by enable, then receive 8'h5A.
  task automatic abort_test(input logic use_en);
    logic [7:0] d;
    int p0, f0, o0;
    d = 8'h3C;
    parity_enable = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    wait_clk(IDLE_CLK);
    check("abort_pre_count", fifo_count, 1);
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
    rx = d[3];
    wait_clk(BIT_CLK / 2);
    check("abort_in_data", current_state, 2);
    if (use_en) begin
      enable = 1'b0;
      @(negedge clk);
    end else begin
      rst_n = 1'b0;
      #1;
    end
    check("abort_rx_valid", rx_valid, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_count", fifo_count, 0);
    check("abort_busy", busy, 0);
    check("abort_state", current_state, 0);
    wait_clk(3);
    rx = 1'b1;
    rst_n = 1'b1;
    enable = 1'b1;
    wait_clk(IDLE_CLK);
    check("abort_perr", perr_cnt - p0, 0);
    check("abort_ferr", ferr_cnt - f0, 0);
    check("abort_ovr", ovr_cnt - o0, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_clk(IDLE_CLK);
    check("abort_next_valid", rx_valid, 1);
    check("abort_next_data", rx_data, 8'h5A);
    check("abort_next_count", fifo_count, 1);
    pop_one();
    check("abort_next_empty", rx_valid, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic       store;
    logic       perr;
    logic       ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, f0, o0;

    //                data  pen   podd  pbit  stop  store perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // basic
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // even ok
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // even bad
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // stop 0
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // odd ok
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // odd ok
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // both bad: frame wins
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // odd bad

    rst_n = 1'b0;
    enable = 1'b1;
    rx = 1'b1;
    rx_read = 1'b0;
    parity_enable = 1'b0;
    parity_odd_even = 1'b0;
    wait_clk(4);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_flags", {parity_err, frame_err, overrun}, 0);
    check("rst_busy", busy, 0);
    check("rst_state", current_state, 0);
    rst_n = 1'b1;
    wait_clk(8);

    // Table of single frames.
    for (int v = 0; v < 8; v++) begin
      parity_enable = vecs[v].pen;
      parity_odd_even = vecs[v].podd;
      p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
      wait_clk(IDLE_CLK);
      check($sformatf("vec%0d_state", v), current_state, 0);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].store);
      check($sformatf("vec%0d_data", v), rx_data, vecs[v].store ? vecs[v].data : 8'h00);
      check($sformatf("vec%0d_count", v), fifo_count, vecs[v].store ? 1 : 0);
      check($sformatf("vec%0d_perr", v), perr_cnt - p0, vecs[v].perr ? 1 : 0);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].ferr ? 1 : 0);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
      if (vecs[v].store) begin
        pop_one();
        check($sformatf("vec%0d_pop_valid", v), rx_valid, 0);
        check($sformatf("vec%0d_pop_data", v), rx_data, 0);
      end
    end

    // Short low glitch on an idle line.
    parity_enable = 1'b0;
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    wait_clk(4 * TICK_DIV);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    wait_clk(IDLE_CLK);
    check("glitch_state", current_state, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_flags", (perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Seventeen back-to-back frames with no reads.
    o0 = ovr_cnt;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    wait_clk(IDLE_CLK);
    check("ovr_count", fifo_count, 16);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_head", rx_data, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_drain%0d", i), rx_data, i);
      pop_one();
    end
    check("ovr_drained", rx_valid, 0);

    // Seventeenth push coincides with a pop while full.
    o0 = ovr_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    check("sim_full", fifo_count, 16);
    fork
      send_frame(8'h10, 1'b0, 1'b0, 1'b1);
      pop_at_push();
    join
    wait_clk(IDLE_CLK);
    check("sim_ovr", ovr_cnt - o0, 0);
    check("sim_count", fifo_count, 16);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("sim_drain%0d", i), rx_data, i);
      pop_one();
    end
    check("sim_drained", rx_valid, 0);

    // Mid-frame abort by reset, then by enable.
    abort_test(1'b0);
    abort_test(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
